// File: rtl/snn_loader_pkg.sv
// Shared state encoding and default widths for the SNN packet loader.
package snn_loader_pkg;

    localparam int DEF_PACKET_WIDTH = 30;
    localparam int DEF_FIFO_AW      = 8;
    localparam int DEF_NUM_OUTPUTS  = 250;
    localparam int DEF_OUT_IDX_W    = 8;
    localparam int DEF_END_TICKS    = 2;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'b000,
        ST_LOAD     = 3'b001,
        ST_COMPUTE  = 3'b010,
        ST_WAIT_END = 3'b100
    } state_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Show-ahead FIFO: the head word is visible on rdata with zero read latency.
module sync_fifo_fwft #(
    parameter int DW = 30,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          winc,
    input  logic [DW-1:0] wdata,
    input  logic          rinc,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level,
    output logic          overflow
);

    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    logic [DW-1:0] mem [0:(2**AW)-1];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   level_reg;
    logic          overflow_reg;
    logic          wr_ok;
    logic          rd_ok;

    // A write into a full FIFO is still accepted when the head is popped in the same cycle.
    assign wr_ok = winc && (!full || rinc);
    assign rd_ok = rinc && !empty;

    assign full     = (level_reg == DEPTH);
    assign empty    = (level_reg == '0);
    assign level    = level_reg;
    assign overflow = overflow_reg;
    assign rdata    = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({wr_ok, rd_ok})
                2'b10:   level_reg <= level_reg + 1'b1;
                2'b01:   level_reg <= level_reg - 1'b1;
                default: level_reg <= level_reg;
            endcase
            if (winc && !wr_ok) begin
                overflow_reg <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/packet_loader_mc.sv
// Packet loader: input FIFO toward the grid, spike-frame accumulator and run sequencer.
module packet_loader_mc
    import snn_loader_pkg::*;
#(
    parameter int PACKET_WIDTH = DEF_PACKET_WIDTH,
    parameter int FIFO_AW      = DEF_FIFO_AW,
    parameter int NUM_OUTPUTS  = DEF_NUM_OUTPUTS,
    parameter int OUT_IDX_W    = DEF_OUT_IDX_W,
    parameter int END_TICKS    = DEF_END_TICKS
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    packet_winc,
    input  logic [PACKET_WIDTH-1:0] packet_wdata,
    output logic                    packet_wfull,
    input  logic                    ren_to_input_buffer,
    output logic [PACKET_WIDTH-1:0] packet_in,
    output logic                    input_buffer_empty,
    output logic [FIFO_AW:0]        fifo_level,
    input  logic                    tick,
    input  logic                    packet_out_valid,
    input  logic [OUT_IDX_W-1:0]    packet_out,
    input  logic                    grid_load_req,
    input  logic                    spike_en,
    input  logic                    load_end,
    output logic [2:0]              state,
    output logic                    complete,
    output logic [NUM_OUTPUTS-1:0]  spike_out,
    output logic                    spike_out_valid,
    output logic [15:0]             frame_count,
    output logic                    overflow,
    output logic                    bad_index
);

    localparam int CNT_W = (END_TICKS < 1) ? 1 : $clog2(END_TICKS + 1);

    state_t                 state_reg;
    logic                   complete_reg;
    logic [NUM_OUTPUTS-1:0] acc_reg;
    logic [NUM_OUTPUTS-1:0] spike_out_reg;
    logic                   spike_out_valid_reg;
    logic [15:0]            frame_count_reg;
    logic                   bad_index_reg;
    logic [CNT_W-1:0]       cnt_end_reg;

    logic [NUM_OUTPUTS-1:0] spike_mask;
    logic                   in_range;
    logic                   publish;

    sync_fifo_fwft #(
        .DW (PACKET_WIDTH),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .winc     (packet_winc),
        .wdata    (packet_wdata),
        .rinc     (ren_to_input_buffer),
        .rdata    (packet_in),
        .full     (packet_wfull),
        .empty    (input_buffer_empty),
        .level    (fifo_level),
        .overflow (overflow)
    );

    assign in_range = int'(packet_out) < NUM_OUTPUTS;

    // Neuron 0 maps to the MSB of the frame.
    for (genvar gi = 0; gi < NUM_OUTPUTS; gi++) begin : g_mask
        assign spike_mask[gi] = packet_out_valid &&
                                (packet_out == OUT_IDX_W'(NUM_OUTPUTS - 1 - gi));
    end

    assign publish = tick && (((state_reg == ST_COMPUTE) && spike_en) ||
                              (state_reg == ST_WAIT_END));

    assign state           = state_reg;
    assign complete        = complete_reg;
    assign spike_out       = spike_out_reg;
    assign spike_out_valid = spike_out_valid_reg;
    assign frame_count     = frame_count_reg;
    assign bad_index       = bad_index_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg           <= ST_IDLE;
            complete_reg        <= 1'b0;
            acc_reg             <= '0;
            spike_out_reg       <= '0;
            spike_out_valid_reg <= 1'b0;
            frame_count_reg     <= '0;
            bad_index_reg       <= 1'b0;
            cnt_end_reg         <= '0;
        end else begin
            spike_out_valid_reg <= publish;
            if (publish) begin
                spike_out_reg   <= acc_reg;
                frame_count_reg <= frame_count_reg + 16'd1;
            end
            // A spike arriving with the tick belongs to the frame that starts now.
            acc_reg <= (tick ? '0 : acc_reg) | spike_mask;
            if (packet_out_valid && !in_range) begin
                bad_index_reg <= 1'b1;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (!input_buffer_empty) begin
                        state_reg    <= ST_LOAD;
                        complete_reg <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (input_buffer_empty) begin
                        state_reg <= ST_COMPUTE;
                    end
                end
                ST_COMPUTE: begin
                    if (load_end) begin
                        state_reg <= ST_WAIT_END;
                    end else if (tick || grid_load_req) begin
                        state_reg <= ST_LOAD;
                    end
                end
                ST_WAIT_END: begin
                    if (cnt_end_reg == CNT_W'(END_TICKS)) begin
                        state_reg    <= ST_IDLE;
                        complete_reg <= 1'b1;
                        cnt_end_reg  <= '0;
                    end else if (tick) begin
                        cnt_end_reg <= cnt_end_reg + 1'b1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_packet_loader_mc.sv
// Directed bench with a scoreboard monitor for FIFO pops and published spike frames.
module tb_packet_loader_mc;

    localparam int PW = 30;
    localparam int AW = 8;
    localparam int NO = 250;
    localparam int IW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          packet_winc;
    logic [PW-1:0] packet_wdata;
    logic          packet_wfull;
    logic          ren_to_input_buffer;
    logic [PW-1:0] packet_in;
    logic          input_buffer_empty;
    logic [AW:0]   fifo_level;
    logic          tick;
    logic          packet_out_valid;
    logic [IW-1:0] packet_out;
    logic          grid_load_req;
    logic          spike_en;
    logic          load_end;
    logic [2:0]    state;
    logic          complete;
    logic [NO-1:0] spike_out;
    logic          spike_out_valid;
    logic [15:0]   frame_count;
    logic          overflow;
    logic          bad_index;

    int vectors     = 0;
    int miscompares = 0;

    logic [PW-1:0] exp_pkt_q[$];
    logic [NO-1:0] exp_frame_q[$];
    logic [15:0]   exp_cnt_q[$];

    packet_loader_mc dut (
        .clk                 (clk),
        .reset               (reset),
        .packet_winc         (packet_winc),
        .packet_wdata        (packet_wdata),
        .packet_wfull        (packet_wfull),
        .ren_to_input_buffer (ren_to_input_buffer),
        .packet_in           (packet_in),
        .input_buffer_empty  (input_buffer_empty),
        .fifo_level          (fifo_level),
        .tick                (tick),
        .packet_out_valid    (packet_out_valid),
        .packet_out          (packet_out),
        .grid_load_req       (grid_load_req),
        .spike_en            (spike_en),
        .load_end            (load_end),
        .state               (state),
        .complete            (complete),
        .spike_out           (spike_out),
        .spike_out_valid     (spike_out_valid),
        .frame_count         (frame_count),
        .overflow            (overflow),
        .bad_index           (bad_index)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Frame with the bit of neuron n set (neuron 0 is the MSB).
    function automatic logic [NO-1:0] nbit(input int n);
        logic [NO-1:0] f;
        f = '0;
        f[NO-1-n] = 1'b1;
        return f;
    endfunction

    task automatic do_tick(input logic en);
        tick = 1'b1;
        spike_en = en;
        cyc();
        tick = 1'b0;
        spike_en = 1'b0;
    endtask

    task automatic spike(input int n);
        packet_out_valid = 1'b1;
        packet_out = IW'(n);
        cyc();
        packet_out_valid = 1'b0;
    endtask

    // Monitor: compares every pop and every published frame against the queues.
    always @(negedge clk) begin
        if (!reset) begin
            if (ren_to_input_buffer && !input_buffer_empty) begin
                if (exp_pkt_q.size() == 0) begin
                    check("unexpected_pop", 256'(packet_in), 256'hDEAD);
                end else begin
                    check("packet_in", 256'(packet_in), 256'(exp_pkt_q.pop_front()));
                end
            end
            if (spike_out_valid) begin
                if (exp_frame_q.size() == 0) begin
                    check("unexpected_frame", 256'(frame_count), 256'hDEAD);
                end else begin
                    check("spike_out", 256'(spike_out), 256'(exp_frame_q.pop_front()));
                    check("frame_count", 256'(frame_count), 256'(exp_cnt_q.pop_front()));
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        packet_winc = 1'b0;
        packet_wdata = '0;
        ren_to_input_buffer = 1'b0;
        tick = 1'b0;
        packet_out_valid = 1'b0;
        packet_out = '0;
        grid_load_req = 1'b0;
        spike_en = 1'b0;
        load_end = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        check("rst_state", 256'(state), 256'(3'b000));
        check("rst_empty", 256'(input_buffer_empty), 256'd1);
        check("rst_level", 256'(fifo_level), 256'd0);
        check("rst_spike_out", 256'(spike_out), 256'd0);
        check("rst_frame_count", 256'(frame_count), 256'd0);
        check("rst_flags", 256'({complete, overflow, bad_index, packet_wfull, spike_out_valid}), 256'd0);

        // Three packets, popped one per cycle
        packet_winc = 1'b1;
        packet_wdata = PW'(1); cyc();
        packet_wdata = PW'(2); cyc();
        packet_wdata = PW'(3); cyc();
        packet_winc = 1'b0;
        check("state_load", 256'(state), 256'(3'b001));
        check("level_3", 256'(fifo_level), 256'd3);
        for (int i = 1; i <= 3; i++) exp_pkt_q.push_back(PW'(i));
        ren_to_input_buffer = 1'b1;
        repeat (3) cyc();
        ren_to_input_buffer = 1'b0;
        check("empty_after_3", 256'(input_buffer_empty), 256'd1);
        cyc();
        check("state_compute", 256'(state), 256'(3'b010));

        // Fill to capacity, overflow, then simultaneous pop+push when full
        packet_winc = 1'b1;
        for (int i = 0; i < 256; i++) begin
            packet_wdata = PW'(i);
            cyc();
        end
        packet_winc = 1'b0;
        check("full_wfull", 256'(packet_wfull), 256'd1);
        check("full_level", 256'(fifo_level), 256'd256);
        check("no_overflow_yet", 256'(overflow), 256'd0);
        packet_winc = 1'b1;
        packet_wdata = 30'h3FFFFFFF;
        cyc();
        packet_winc = 1'b0;
        check("overflow_set", 256'(overflow), 256'd1);
        check("overflow_level", 256'(fifo_level), 256'd256);
        exp_pkt_q.push_back(PW'(0));
        packet_winc = 1'b1;
        ren_to_input_buffer = 1'b1;
        packet_wdata = 30'hABC;
        cyc();
        packet_winc = 1'b0;
        check("rw_full_level", 256'(fifo_level), 256'd256);
        for (int i = 1; i < 256; i++) exp_pkt_q.push_back(PW'(i));
        exp_pkt_q.push_back(30'hABC);
        repeat (256) cyc();
        ren_to_input_buffer = 1'b0;
        check("drained_level", 256'(fifo_level), 256'd0);
        check("overflow_sticky", 256'(overflow), 256'd1);
        check("still_compute", 256'(state), 256'(3'b010));

        // Spikes on neurons 0 and 249, then a publishing tick
        spike(0);
        spike(249);
        exp_frame_q.push_back(nbit(0) | nbit(249));
        exp_cnt_q.push_back(16'd1);
        do_tick(1'b1);
        check("valid_pulse", 256'(spike_out_valid), 256'd1);
        cyc();
        check("valid_drop", 256'(spike_out_valid), 256'd0);
        check("back_compute", 256'(state), 256'(3'b010));

        // Spike coincident with tick goes to the next frame
        spike(10);
        exp_frame_q.push_back(nbit(10));
        exp_cnt_q.push_back(16'd2);
        packet_out_valid = 1'b1;
        packet_out = IW'(5);
        do_tick(1'b1);
        packet_out_valid = 1'b0;
        cyc();
        exp_frame_q.push_back(nbit(5));
        exp_cnt_q.push_back(16'd3);
        do_tick(1'b1);
        cyc();

        // Out-of-range index is dropped
        spike(1);
        spike(250);
        check("bad_index", 256'(bad_index), 256'd1);
        exp_frame_q.push_back(nbit(1));
        exp_cnt_q.push_back(16'd4);
        do_tick(1'b1);
        cyc();

        // End of run: two drain ticks, then complete
        load_end = 1'b1;
        cyc();
        load_end = 1'b0;
        check("state_wait_end", 256'(state), 256'(3'b100));
        spike(2);
        exp_frame_q.push_back(nbit(2));
        exp_cnt_q.push_back(16'd5);
        do_tick(1'b0);
        check("not_complete_yet", 256'(complete), 256'd0);
        exp_frame_q.push_back('0);
        exp_cnt_q.push_back(16'd6);
        do_tick(1'b0);
        check("wait_after_2", 256'(state), 256'(3'b100));
        cyc();
        check("idle_after_end", 256'(state), 256'(3'b000));
        check("complete_set", 256'(complete), 256'd1);
        packet_winc = 1'b1;
        packet_wdata = 30'h55;
        cyc();
        packet_winc = 1'b0;
        cyc();
        check("restart_load", 256'(state), 256'(3'b001));
        check("complete_clear", 256'(complete), 256'd0);
        exp_pkt_q.push_back(30'h55);
        ren_to_input_buffer = 1'b1;
        cyc();
        ren_to_input_buffer = 1'b0;
        cyc();

        // Reset mid-run drops FIFO contents
        packet_winc = 1'b1;
        packet_wdata = 30'h7; cyc();
        packet_wdata = 30'h8; cyc();
        packet_winc = 1'b0;
        check("pre_reset_level", 256'(fifo_level), 256'd2);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("mid_rst_empty", 256'(input_buffer_empty), 256'd1);
        check("mid_rst_level", 256'(fifo_level), 256'd0);
        check("mid_rst_state", 256'(state), 256'(3'b000));
        check("mid_rst_frames", 256'(frame_count), 256'd0);
        check("mid_rst_flags", 256'({overflow, bad_index, complete}), 256'd0);

        cyc();
        check("pkt_queue_drained", 256'(exp_pkt_q.size()), 256'd0);
        check("frame_queue_drained", 256'(exp_frame_q.size()), 256'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
